// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: request/writeback bundles, FSM states
// and the boolean shorthands used across the pipeline.
`ifndef MEM_STAGE_BOOL_DEFS
`define MEM_STAGE_BOOL_DEFS
`define MS_TRUE  1'b1
`define MS_FALSE 1'b0
`endif

package mem_stage_pkg;

   localparam int MS_DATA_W = 32;
   localparam int MS_REG_AW = 5;

   // Request bundle handed over by the execute FU.
   typedef struct packed {
      logic                 valid;
      logic                 mem_read_ena;
      logic                 mem_write_ena;
      logic                 write_reg_need;
      logic [MS_REG_AW-1:0] write_reg_addr;
      logic [MS_DATA_W-1:0] result;
      logic [MS_DATA_W-1:0] addr;
      logic [MS_DATA_W-1:0] write_data;
   } mem_require_t;

   // Writeback bundle; also the forwarding source for younger instructions.
   typedef struct packed {
      logic                 valid;
      logic                 write_reg_need;
      logic [MS_REG_AW-1:0] write_reg_addr;
      logic [MS_DATA_W-1:0] write_data;
   } wb_require_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   function automatic logic is_misaligned(input logic [1:0] addr_lsb);
      return addr_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundles the execute-side request, data-memory handshake and writeback outputs of
// the memory stage. master = the stage itself, slave = its surroundings.
interface mem_stage_if #(
   parameter int DATA_W = mem_stage_pkg::MS_DATA_W,
   parameter int REG_AW = mem_stage_pkg::MS_REG_AW
);

   logic              in_valid;
   logic              in_mem_read_ena;
   logic              in_mem_write_ena;
   logic              in_write_reg_need;
   logic [REG_AW-1:0] in_write_reg_addr;
   logic [DATA_W-1:0] in_result;
   logic [DATA_W-1:0] in_addr;
   logic [DATA_W-1:0] in_write_data;
   logic              flush;
   logic              stall;

   logic              dmem_req;
   logic              dmem_we;
   logic [DATA_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_ready;
   logic [DATA_W-1:0] dmem_rdata;

   logic              wb_valid;
   logic              wb_write_reg_need;
   logic [REG_AW-1:0] wb_write_reg_addr;
   logic [DATA_W-1:0] wb_write_data;
   logic              addr_err;

   modport master (
      input  in_valid, in_mem_read_ena, in_mem_write_ena, in_write_reg_need,
             in_write_reg_addr, in_result, in_addr, in_write_data, flush,
             dmem_ready, dmem_rdata,
      output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
             wb_valid, wb_write_reg_need, wb_write_reg_addr, wb_write_data, addr_err
   );

   modport slave (
      output in_valid, in_mem_read_ena, in_mem_write_ena, in_write_reg_need,
             in_write_reg_addr, in_result, in_addr, in_write_data, flush,
             dmem_ready, dmem_rdata,
      input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
             wb_valid, wb_write_reg_need, wb_write_reg_addr, wb_write_data, addr_err
   );

endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over a variable-latency handshake,
// registered writeback bundle that doubles as the forwarding source.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = MS_DATA_W,
   parameter int REG_AW = MS_REG_AW
) (
   input  logic        clk,
   input  logic        rst,
   mem_stage_if.master bus
);

   mem_require_t      req;
   mem_state_t        state;
   wb_require_t       wb_q;
   logic              addr_err_q;
   logic              is_mem;

   logic              acc_we;
   logic [DATA_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              acc_reg_need;
   logic [REG_AW-1:0] acc_reg_addr;

   assign req = '{
      valid:          bus.in_valid,
      mem_read_ena:   bus.in_mem_read_ena,
      mem_write_ena:  bus.in_mem_write_ena,
      write_reg_need: bus.in_write_reg_need,
      write_reg_addr: bus.in_write_reg_addr,
      result:         bus.in_result,
      addr:           bus.in_addr,
      write_data:     bus.in_write_data
   };

   assign is_mem = req.mem_read_ena | req.mem_write_ena;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every register, the access latch included, is cleared by the async reset so
      // an abandoned request leaves nothing stale on the memory bus; all state uses <=.
      if (rst) begin
         state        <= IDLE;
         acc_we       <= `MS_FALSE;
         acc_addr     <= '0;
         acc_wdata    <= '0;
         acc_reg_need <= `MS_FALSE;
         acc_reg_addr <= '0;
         wb_q         <= '0;
         addr_err_q   <= `MS_FALSE;
      end else begin
         addr_err_q <= `MS_FALSE;
         case (state)
            IDLE: begin
               if (req.valid && !bus.flush) begin
                  if (!is_mem) begin
                     wb_q <= '{valid:          `MS_TRUE,
                               write_reg_need: req.write_reg_need,
                               write_reg_addr: req.write_reg_addr,
                               write_data:     req.result};
                  end else if (is_misaligned(req.addr[1:0])) begin
                     wb_q.valid          <= `MS_TRUE;
                     wb_q.write_reg_need <= `MS_FALSE;
                     addr_err_q          <= `MS_TRUE;
                  end else begin
                     // A request with both enables set is resolved as a store.
                     acc_we              <= req.mem_write_ena;
                     acc_addr            <= req.addr;
                     acc_wdata           <= req.write_data;
                     acc_reg_need        <= req.write_reg_need;
                     acc_reg_addr        <= req.write_reg_addr;
                     wb_q.valid          <= `MS_FALSE;
                     wb_q.write_reg_need <= `MS_FALSE;
                     state               <= ACCESS;
                  end
               end else begin
                  wb_q.valid          <= `MS_FALSE;
                  wb_q.write_reg_need <= `MS_FALSE;
               end
            end

            ACCESS: begin
               // flush is ignored here: the in-flight op is older than the branch.
               if (bus.dmem_ready) begin
                  state      <= IDLE;
                  wb_q.valid <= `MS_TRUE;
                  if (acc_we) begin
                     wb_q.write_reg_need <= `MS_FALSE;
                  end else begin
                     wb_q.write_reg_need <= acc_reg_need;
                     wb_q.write_reg_addr <= acc_reg_addr;
                     wb_q.write_data     <= bus.dmem_rdata;
                  end
               end else begin
                  wb_q.valid          <= `MS_FALSE;
                  wb_q.write_reg_need <= `MS_FALSE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall             = (state == ACCESS);
   assign bus.dmem_req          = (state == ACCESS);
   assign bus.dmem_we           = acc_we;
   assign bus.dmem_addr         = acc_addr;
   assign bus.dmem_wdata        = acc_wdata;

   assign bus.wb_valid          = wb_q.valid;
   assign bus.wb_write_reg_need = wb_q.write_reg_need;
   assign bus.wb_write_reg_addr = wb_q.write_reg_addr;
   assign bus.wb_write_data     = wb_q.write_data;
   assign bus.addr_err          = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: constant vector table, directed multi-cycle
// sequences and randomized ops against a transaction-level model with a shadow memory.
module tb_mem_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
   mem_stage #(.DATA_W(DW), .REG_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        valid;
      logic        rd;
      logic        wr;
      logic        need;
      logic [4:0]  reg_addr;
      logic [31:0] result;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        flush;
   } op_t;

   typedef struct {
      op_t         op;
      logic        exp_valid;
      logic        exp_need;
      logic        exp_err;
      logic        chk_data;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] mem_dev [256];   // the memory device the DUT talks to
   logic [31:0] ref_mem [256];   // model's view of what memory should hold

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic op_t mk(input logic valid, input logic rd, input logic wr,
                              input logic need, input logic [4:0] reg_addr,
                              input logic [31:0] result, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic flush);
      op_t o;
      o.valid = valid; o.rd = rd; o.wr = wr; o.need = need; o.reg_addr = reg_addr;
      o.result = result; o.addr = addr; o.wdata = wdata; o.flush = flush;
      return o;
   endfunction

   task automatic drive(input op_t op);
      bus.in_valid          = op.valid;
      bus.in_mem_read_ena   = op.rd;
      bus.in_mem_write_ena  = op.wr;
      bus.in_write_reg_need = op.need;
      bus.in_write_reg_addr = op.reg_addr;
      bus.in_result         = op.result;
      bus.in_addr           = op.addr;
      bus.in_write_data     = op.wdata;
      bus.flush             = op.flush;
   endtask

   task automatic drive_idle();
      drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0));
   endtask

   // Issues one op from a negedge in IDLE and returns on the negedge after it retires.
   task automatic run_op(input string tag, input op_t op, input int lat, input logic flush_acc);
      logic        accept, is_mem, mis, do_access;
      logic [7:0]  idx;
      logic        e_valid, e_need, e_err, chk_data;
      logic [4:0]  e_addr;
      logic [31:0] e_data;

      accept    = op.valid && !op.flush;
      is_mem    = op.rd || op.wr;
      mis       = op.addr[1:0] != 2'b00;
      do_access = accept && is_mem && !mis;
      idx       = op.addr[9:2];

      e_valid = accept; e_need = 1'b0; e_err = 1'b0; chk_data = 1'b0;
      e_addr = op.reg_addr; e_data = op.result;
      if (accept && !is_mem) begin
         e_need = op.need; chk_data = 1'b1;
      end else if (accept && mis) begin
         e_err = 1'b1;
      end else if (do_access && !op.wr) begin
         e_need = op.need; e_data = ref_mem[idx]; chk_data = 1'b1;
      end

      drive(op);
      @(posedge clk);
      @(negedge clk);

      if (do_access) begin
         for (int k = 1; k <= lat; k++) begin
            bus.flush = flush_acc;
            check($sformatf("%s acc%0d stall", tag, k), 64'(bus.stall), 64'(1'b1));
            check($sformatf("%s acc%0d dmem_req", tag, k), 64'(bus.dmem_req), 64'(1'b1));
            check($sformatf("%s acc%0d dmem_addr", tag, k), 64'(bus.dmem_addr), 64'(op.addr));
            check($sformatf("%s acc%0d dmem_we", tag, k), 64'(bus.dmem_we), 64'(op.wr));
            if (op.wr)
               check($sformatf("%s acc%0d dmem_wdata", tag, k), 64'(bus.dmem_wdata), 64'(op.wdata));
            check($sformatf("%s acc%0d wb_valid", tag, k), 64'(bus.wb_valid), 64'(1'b0));
            if (k == lat) begin
               bus.dmem_ready = 1'b1;
               bus.dmem_rdata = mem_dev[bus.dmem_addr[9:2]];
               if (bus.dmem_we) mem_dev[bus.dmem_addr[9:2]] = bus.dmem_wdata;
            end else begin
               bus.dmem_ready = 1'b0;
               bus.dmem_rdata = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
         end
         bus.dmem_ready = 1'b0;
         if (op.wr) ref_mem[idx] = op.wdata;
      end else begin
         check($sformatf("%s stall", tag), 64'(bus.stall), 64'(1'b0));
         check($sformatf("%s dmem_req", tag), 64'(bus.dmem_req), 64'(1'b0));
      end
      drive_idle();

      check($sformatf("%s wb_valid", tag), 64'(bus.wb_valid), 64'(e_valid));
      check($sformatf("%s wb_need", tag), 64'(bus.wb_write_reg_need), 64'(e_need));
      check($sformatf("%s addr_err", tag), 64'(bus.addr_err), 64'(e_err));
      if (chk_data) begin
         check($sformatf("%s wb_addr", tag), 64'(bus.wb_write_reg_addr), 64'(e_addr));
         check($sformatf("%s wb_data", tag), 64'(bus.wb_write_data), 64'(e_data));
      end
      check($sformatf("%s post stall", tag), 64'(bus.stall), 64'(1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vec [9];
      op_t  op;

      for (int i = 0; i < 256; i++) begin
         logic [31:0] v;
         v = $urandom;
         mem_dev[i] = v;
         ref_mem[i] = v;
      end

      // --- reset state, no clock edge needed ---
      rst = 1'b1;
      drive_idle();
      bus.dmem_ready = 1'b0;
      bus.dmem_rdata = '0;
      #1;
      check("reset stall", 64'(bus.stall), 64'(1'b0));
      check("reset dmem_req", 64'(bus.dmem_req), 64'(1'b0));
      check("reset dmem_we", 64'(bus.dmem_we), 64'(1'b0));
      check("reset dmem_addr", 64'(bus.dmem_addr), 64'(0));
      check("reset dmem_wdata", 64'(bus.dmem_wdata), 64'(0));
      check("reset wb_valid", 64'(bus.wb_valid), 64'(1'b0));
      check("reset wb_need", 64'(bus.wb_write_reg_need), 64'(1'b0));
      check("reset wb_addr", 64'(bus.wb_write_reg_addr), 64'(0));
      check("reset wb_data", 64'(bus.wb_write_data), 64'(0));
      check("reset addr_err", 64'(bus.addr_err), 64'(1'b0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // --- single-cycle vector table (applied in order; holds depend on prior rows) ---
      //             valid rd    wr    need  reg    result         addr           wdata   flush
      vec[0].op = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  32'h1234_5678, 32'h0,         32'h0,  1'b0);
      vec[1].op = mk(1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h0000_AAAA, 32'h0,         32'h0,  1'b0);
      vec[2].op = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0000_0055, 32'h0,         32'h0,  1'b0);
      vec[3].op = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0099, 32'h0000_0102, 32'h0,  1'b0);
      vec[4].op = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  32'h0000_0077, 32'h0,         32'h0,  1'b1);
      vec[5].op = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0,         32'h0,  1'b0);
      vec[6].op = mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd2,  32'h0,         32'h0000_0203, 32'h11, 1'b0);
      vec[7].op = mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd4,  32'h0,         32'h0000_0100, 32'h0,  1'b1);
      vec[8].op = mk(1'b1, 1'b1, 1'b1, 1'b1, 5'd6,  32'h0,         32'h0000_0001, 32'h22, 1'b0);
      //                 valid            need             err              chk_data         addr                data
      vec[0].exp_valid = 1'b1; vec[0].exp_need = 1'b1; vec[0].exp_err = 1'b0; vec[0].chk_data = 1'b1; vec[0].exp_addr = 5'd8; vec[0].exp_data = 32'h1234_5678;
      vec[1].exp_valid = 1'b0; vec[1].exp_need = 1'b0; vec[1].exp_err = 1'b0; vec[1].chk_data = 1'b1; vec[1].exp_addr = 5'd8; vec[1].exp_data = 32'h1234_5678;
      vec[2].exp_valid = 1'b1; vec[2].exp_need = 1'b0; vec[2].exp_err = 1'b0; vec[2].chk_data = 1'b1; vec[2].exp_addr = 5'd5; vec[2].exp_data = 32'h0000_0055;
      vec[3].exp_valid = 1'b1; vec[3].exp_need = 1'b0; vec[3].exp_err = 1'b1; vec[3].chk_data = 1'b0; vec[3].exp_addr = 5'd0; vec[3].exp_data = 32'h0;
      vec[4].exp_valid = 1'b0; vec[4].exp_need = 1'b0; vec[4].exp_err = 1'b0; vec[4].chk_data = 1'b0; vec[4].exp_addr = 5'd0; vec[4].exp_data = 32'h0;
      vec[5].exp_valid = 1'b1; vec[5].exp_need = 1'b1; vec[5].exp_err = 1'b0; vec[5].chk_data = 1'b1; vec[5].exp_addr = 5'd0; vec[5].exp_data = 32'hFFFF_FFFF;
      vec[6].exp_valid = 1'b1; vec[6].exp_need = 1'b0; vec[6].exp_err = 1'b1; vec[6].chk_data = 1'b0; vec[6].exp_addr = 5'd0; vec[6].exp_data = 32'h0;
      vec[7].exp_valid = 1'b0; vec[7].exp_need = 1'b0; vec[7].exp_err = 1'b0; vec[7].chk_data = 1'b0; vec[7].exp_addr = 5'd0; vec[7].exp_data = 32'h0;
      vec[8].exp_valid = 1'b1; vec[8].exp_need = 1'b0; vec[8].exp_err = 1'b1; vec[8].chk_data = 1'b0; vec[8].exp_addr = 5'd0; vec[8].exp_data = 32'h0;

      for (int i = 0; i < 9; i++) begin
         drive(vec[i].op);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("tbl%0d wb_valid", i), 64'(bus.wb_valid), 64'(vec[i].exp_valid));
         check($sformatf("tbl%0d wb_need", i), 64'(bus.wb_write_reg_need), 64'(vec[i].exp_need));
         check($sformatf("tbl%0d addr_err", i), 64'(bus.addr_err), 64'(vec[i].exp_err));
         check($sformatf("tbl%0d stall", i), 64'(bus.stall), 64'(1'b0));
         check($sformatf("tbl%0d dmem_req", i), 64'(bus.dmem_req), 64'(1'b0));
         if (vec[i].chk_data) begin
            check($sformatf("tbl%0d wb_addr", i), 64'(bus.wb_write_reg_addr), 64'(vec[i].exp_addr));
            check($sformatf("tbl%0d wb_data", i), 64'(bus.wb_write_data), 64'(vec[i].exp_data));
         end
      end
      drive_idle();
      @(negedge clk);

      // --- load, 3 ACCESS cycles before dmem_ready ---
      mem_dev[8'h40] = 32'hDEAD_BEEF;
      ref_mem[8'h40] = 32'hDEAD_BEEF;
      run_op("load3", mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0, 32'h0000_0100, 32'h0, 1'b0), 3, 1'b0);

      // --- store, immediate ready, then read it back ---
      run_op("store1", mk(1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 32'h0, 32'h0000_0200, 32'hCAFE_F00D, 1'b0), 1, 1'b0);
      run_op("loadback", mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0000_0200, 32'h0, 1'b0), 2, 1'b0);
      check("store reached memory", 64'(mem_dev[8'h80]), 64'(32'hCAFE_F00D));

      // --- misaligned load: addr_err lasts exactly one cycle ---
      run_op("misload", mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0000_0102, 32'h0, 1'b0), 1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("misload addr_err cleared", 64'(bus.addr_err), 64'(1'b0));
      check("misload no dmem_req", 64'(bus.dmem_req), 64'(1'b0));

      // --- flush during ACCESS does not kill the older op ---
      run_op("flushacc", mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0, 32'h0000_0010, 32'h0, 1'b0), 2, 1'b1);

      // --- reset mid-ACCESS with dmem_ready low ---
      drive(mk(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0000_0040, 32'h0, 1'b0));
      @(posedge clk);
      @(negedge clk);
      check("rstacc pre dmem_req", 64'(bus.dmem_req), 64'(1'b1));
      #1 rst = 1'b1;
      #1;
      check("rstacc dmem_req", 64'(bus.dmem_req), 64'(1'b0));
      check("rstacc stall", 64'(bus.stall), 64'(1'b0));
      check("rstacc wb_valid", 64'(bus.wb_valid), 64'(1'b0));
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // --- randomized ops against the transaction model ---
      for (int t = 0; t < 300; t++) begin
         int sel;
         sel = $urandom_range(0, 3);
         op.valid    = ($urandom_range(0, 9) != 0);
         op.flush    = ($urandom_range(0, 9) == 0);
         op.rd       = (sel == 1) || (sel == 3);
         op.wr       = (sel == 2) || (sel == 3);
         op.need     = 1'($urandom_range(0, 1));
         op.reg_addr = 5'($urandom_range(0, 31));
         op.result   = $urandom;
         op.wdata    = $urandom;
         op.addr     = {22'd0, 8'($urandom_range(0, 255)),
                        ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         run_op($sformatf("rnd%0d", t), op, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute FU.
- Consumes the FU's memory request bundle and performs word loads/stores through a variable-latency data-memory handshake.
- Registers the writeback bundle for the WB stage and exposes a forwarding copy.
- Stalls upstream while a memory access is outstanding.

Parameters:
- DATA_W, 32, data and address width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute stage presents a valid mem request this cycle.
- in_mem_read_ena  in  1  operation is a load (lw).
- in_mem_write_ena  in  1  operation is a store (sw).
- in_write_reg_need  in  1  operation writes the register file.
- in_write_reg_addr  in  REG_AW  destination register.
- in_result  in  DATA_W  ALU result, or pc+8 for link.
- in_addr  in  DATA_W  effective memory address.
- in_write_data  in  DATA_W  store data.
- flush  in  1  kill the younger instruction (branch mispredict).
- stall  out  1  upstream must hold; in_ready = !stall.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_W  word address, bits [1:0] = 0.
- dmem_wdata  out  DATA_W  store data.
- dmem_ready  in  1  request accepted/completed this cycle.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready && !dmem_we.
- wb_valid  out  1  writeback bundle valid.
- wb_write_reg_need  out  1  writeback enable.
- wb_write_reg_addr  out  REG_AW  writeback destination.
- wb_write_data  out  DATA_W  writeback value.
- addr_err  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - All wb_* outputs 0; addr_err 0.
  - dmem_req 0; dmem_we/addr/wdata 0.
  - stall 0; internal latch cleared.
- FSM states:
  - IDLE: accepting.
  - ACCESS: memory request outstanding.
- stall = (state == ACCESS). There is no combinational path from in_* to stall.
- IDLE, in_valid=1, flush=0:
  - Non-memory op: at the next edge wb_valid=1, wb_write_reg_need/addr copied from the input, wb_write_data=in_result. Latency 1.
  - Memory op with in_addr[1:0]==0: latch addr, write_data, we (=in_mem_write_ena), reg need/addr; go to ACCESS. wb_valid=0 at the next edge.
  - Memory op with in_addr[1:0]!=0: no memory access. Next edge: addr_err=1 for exactly one cycle, wb_valid=1, wb_write_reg_need=0. Stay in IDLE.
  - in_mem_read_ena and in_mem_write_ena both 1 is illegal; treat it as a store.
- IDLE, in_valid=0 or flush=1: next edge wb_valid=0, wb_write_reg_need=0; other wb fields hold.
- ACCESS:
  - dmem_req=1, driven only from latched values; dmem_req, dmem_addr, dmem_we and dmem_wdata are held stable until dmem_ready.
  - dmem_ready=1: next edge returns to IDLE and sets wb_valid=1.
    - Load: wb_write_data=dmem_rdata; wb_write_reg_need/addr from the latch.
    - Store: wb_write_reg_need=0.
  - dmem_ready=0: stay in ACCESS, wb_valid=0.
- Minimum memory-op latency is 2 cycles (dmem_ready in the first ACCESS cycle). Back-to-back memory ops are therefore issued at most every 2 cycles.
- flush while in ACCESS:
  - The request is not aborted; the handshake completes.
  - A flush arriving in ACCESS does not kill the in-flight op: it is older than the flushing branch and completes normally.
  - While in ACCESS, flush only blocks acceptance, which is already blocked by stall.
- The upstream pipeline register holds in_* while stall=1; this block ignores in_* during ACCESS.
- Forwarding: the wb_* register outputs double as the bypass source; consumers qualify them with wb_valid && wb_write_reg_need.
- Reset asserted mid-ACCESS drops dmem_req immediately. The memory model must tolerate an abandoned request.
- Writes to register 0 are passed through unchanged; the register file ignores them.

Decomposition:
- Shared package/defines header:
  - Extend the existing MEM_REQUIRE struct with a valid bit.
  - Add a WB_REQUIRE struct {valid, write_reg_need, write_reg_addr, write_data}.
  - Add MEM_STATE enum {IDLE, ACCESS}.
  - Add `true/`false.
- Sub-module: none. The datapath is a latch plus a 2-state FSM; the misalignment check is a single compare kept inline.

Test Plan:
- Reset: assert rst mid-ACCESS with dmem_ready held 0 → dmem_req=0, stall=0 and wb_valid=0 in the same cycle, with no clock edge needed.
- ALU op: in_result=0x1234_5678, reg 8, need=1 → one cycle later wb_valid=1, addr=8, data=0x12345678, stall never asserted.
- Load with 3-cycle memory latency: addr=0x0000_0100, reg 9, dmem_ready after 3 ACCESS cycles with rdata=0xDEAD_BEEF → stall high 3 cycles, dmem_addr stable at 0x100, then wb reg 9 = 0xDEADBEEF.
- Store: addr=0x200, data=0xCAFE_F00D, dmem_ready immediate → dmem_we=1 and wdata=0xCAFEF00D for 1 cycle; wb_valid=1 with wb_write_reg_need=0.
- Misaligned load: addr=0x0000_0102 → no dmem_req, addr_err pulses exactly 1 cycle, wb_write_reg_need=0, state stays IDLE.
- Flush in IDLE with a valid load presented → no dmem_req and wb_valid=0 next cycle.
- Flush during ACCESS → the access still completes and writes back.
